// File: rtl/vga_pkg.sv
// vga_pkg: shared screen geometry, glyph codes and frame-writer FSM states
package vga_pkg;
  localparam int WIDTH = 120;
  localparam int HEIGHT = 40;
  localparam int CELLS = WIDTH * HEIGHT;
  localparam logic [7:0] GLYPH_BLANK = 8'd0;
  localparam logic [7:0] GLYPH_BLOCK = 8'd1;
  localparam logic [7:0] GLYPH_VBAR = 8'd2;
  localparam logic [7:0] GLYPH_HBAR = 8'd3;
  localparam logic [7:0] GLYPH_CROSS = 8'd4;
  localparam logic [7:0] GLYPH_TEE_T = 8'd5;
  localparam logic [7:0] GLYPH_TEE_B = 8'd6;
  localparam logic [7:0] GLYPH_CORNER_TL = 8'd7;
  localparam logic [7:0] GLYPH_CORNER_TR = 8'd8;
  localparam logic [7:0] GLYPH_CORNER_BL = 8'd9;
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_CLR_GAP, S_DRAIN, S_SETUP, S_PULSE, S_ACT, S_DONE
  } state_t;
endpackage

// File: rtl/vga_cmd_fifo.sv
// vga_cmd_fifo: synchronous FIFO with registered occupancy count
module vga_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/vga_frame_writer.sv
// vga_frame_writer: queues cell writes and replays them to the text-mode sink
// as clean edge-safe strobes, optionally preceded by a clear and followed by activate.
module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int height = HEIGHT,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        frame_req,
  input  logic        frame_clear,
  output logic        busy,
  output logic        frame_done,
  output logic        addr_err,
  output logic        vga_activate,
  output logic        vga_clear,
  output logic        vga_write,
  output logic [15:0] vga_addr,
  output logic [15:0] vga_data
);
  localparam logic [16:0] LIMIT = 17'(width * height);
  state_t state, nxt;
  logic full, empty, pop, in_range;
  logic [23:0] head;
  vga_cmd_fifo #(.DEPTH(DEPTH), .W(24)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(cmd_valid),
    .pop(pop),
    .din({cmd_addr, cmd_data}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign cmd_ready = !full;
  assign pop = state == S_DRAIN && !empty;
  assign in_range = {1'b0, head[23:8]} < LIMIT;
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = frame_req ? (frame_clear ? S_CLR : S_DRAIN) : S_IDLE;
      S_CLR:     nxt = S_CLR_GAP;
      S_CLR_GAP: nxt = S_DRAIN;
      S_DRAIN:   nxt = empty ? S_ACT : (in_range ? S_SETUP : S_DRAIN);
      S_SETUP:   nxt = S_PULSE;
      S_PULSE:   nxt = S_DRAIN;
      S_ACT:     nxt = S_DONE;
      default:   nxt = S_IDLE;
    endcase
  end
  // Strobes are registered from the next state so each is high exactly while in its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_clear <= 1'b0;
      vga_write <= 1'b0;
      vga_activate <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      addr_err <= 1'b0;
      vga_addr <= '0;
      vga_data <= '0;
    end else begin
      vga_clear <= nxt == S_CLR;
      vga_write <= nxt == S_PULSE;
      vga_activate <= nxt == S_ACT;
      frame_done <= nxt == S_DONE;
      busy <= nxt != S_IDLE;
      addr_err <= (state == S_IDLE && frame_req) ? 1'b0 : (pop && !in_range) ? 1'b1 : addr_err;
      if (pop && in_range) begin
        vga_addr <= head[23:8];
        vga_data <= {8'h00, head[7:0]};
      end
    end
  end
endmodule

// File: tb/tb_vga_frame_writer.sv
// tb_vga_frame_writer: random and directed frames checked against a queue model of the sink writes
module tb_vga_frame_writer;
  localparam int CELLS = 4800;
  localparam int DEPTH = 16;
  typedef struct { logic [15:0] a; logic [7:0] d; } cmd_t;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, frame_req = 0, frame_clear = 0;
  logic [15:0] cmd_addr = 0;
  logic [7:0] cmd_data = 0;
  logic cmd_ready, busy, frame_done, addr_err, vga_activate, vga_clear, vga_write;
  logic [15:0] vga_addr, vga_data;
  cmd_t q[$];
  int n_checks = 0, n_fail = 0;
  int n_clr, n_act, n_done, n_wr;
  logic exp_err = 0;
  logic pw = 0, pc = 0, pa = 0;
  logic [15:0] paddr = 0, pdata = 0;
  vga_frame_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .frame_req(frame_req), .frame_clear(frame_clear),
    .busy(busy), .frame_done(frame_done), .addr_err(addr_err),
    .vga_activate(vga_activate), .vga_clear(vga_clear), .vga_write(vga_write),
    .vga_addr(vga_addr), .vga_data(vga_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Sink-side monitor: every write rising edge must match the oldest in-range queued command.
  always @(negedge clk) begin
    cmd_t e;
    if (vga_write) begin
      n_wr++;
      check("wr_width", pw, 0);
      check("wr_setup", {paddr, pdata}, {vga_addr, vga_data});
      while (q.size() > 0 && q[0].a >= CELLS) begin
        void'(q.pop_front());
        exp_err = 1;
      end
      if (q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        check("wr_addr", vga_addr, e.a);
        check("wr_data", vga_data, {8'h00, e.d});
      end
    end
    if (vga_clear) begin n_clr++; check("clr_width", pc, 0); end
    if (vga_activate) begin n_act++; check("act_width", pa, 0); end
    if (frame_done) n_done++;
    pw = vga_write; pc = vga_clear; pa = vga_activate;
    paddr = vga_addr; pdata = vga_data;
  end
  task automatic push_one(input logic [15:0] a, input logic [7:0] d, input bit chk);
    cmd_t e;
    @(posedge clk); #1;
    if (chk) check("ready", cmd_ready, q.size() < DEPTH);
    cmd_valid = 1; cmd_addr = a; cmd_data = d;
    e.a = a; e.d = d;
    if (q.size() < DEPTH) q.push_back(e);
  endtask
  task automatic end_push;
    @(posedge clk); #1 cmd_valid = 0;
  endtask
  function automatic logic [15:0] rand_addr;
    return ($urandom % 10 == 0) ? 16'($urandom_range(CELLS, 65535)) : 16'($urandom_range(0, CELLS - 1));
  endfunction
  task automatic run_frame(input logic clr, input bit req_mid, input int mid_push);
    int t;
    n_clr = 0; n_act = 0; n_done = 0; n_wr = 0; exp_err = 0;
    @(posedge clk); #1 frame_req = 1; frame_clear = clr;
    @(posedge clk); #1 frame_req = 0; frame_clear = 0;
    @(negedge clk);
    check("busy_start", busy, 1);
    check("err_cleared", addr_err, 0);
    for (int i = 0; i < mid_push; i++) push_one(16'($urandom_range(0, CELLS - 1)), 8'($urandom_range(0, 9)), 0);
    if (mid_push > 0) end_push();
    if (req_mid) begin
      t = 0;
      while (!vga_write && t < 200) begin @(negedge clk); t++; end
      check("pulse_seen", vga_write, 1);
      frame_req = 1;
      @(posedge clk); #1 frame_req = 0;
    end
    t = 0;
    while (!frame_done && t < 400) begin @(negedge clk); t++; end
    check("done_timeout", frame_done, 1);
    @(negedge clk);
    while (q.size() > 0 && q[0].a >= CELLS) begin void'(q.pop_front()); exp_err = 1; end
    check("queue_drained", q.size(), 0);
    check("n_clear", n_clr, clr);
    check("n_activate", n_act, 1);
    check("n_done", n_done, 1);
    check("addr_err", addr_err, exp_err);
    check("busy_end", busy, 0);
    if (req_mid) begin
      repeat (5) @(negedge clk);
      check("no_second_frame", {busy, 8'(n_done)}, {1'b0, 8'd1});
    end
  endtask
  initial begin
    int t, n;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_outs", {busy, frame_done, addr_err, vga_activate, vga_clear, vga_write}, 0);
    check("rst_bus", {vga_addr, vga_data}, 0);
    check("rst_ready", cmd_ready, 1);
    // Empty frame, exact cycle timing
    n_act = 0; n_done = 0;
    @(posedge clk); #1 frame_req = 1;
    @(posedge clk); #1 frame_req = 0;
    @(negedge clk); check("t1_drain", {busy, vga_activate, frame_done}, 3'b100);
    @(negedge clk); check("t1_act", {busy, vga_activate, frame_done}, 3'b110);
    @(negedge clk); check("t1_done", {busy, vga_activate, frame_done}, 3'b101);
    @(negedge clk); check("t1_idle", {busy, vga_activate, frame_done}, 3'b000);
    // Three writes with a clear
    push_one(16'd5, 8'd1, 1); push_one(16'd120, 8'd2, 1); push_one(16'd4799, 8'd9, 1);
    end_push();
    run_frame(1, 0, 0);
    check("t2_nwr", n_wr, 3);
    check("t2_last", {vga_addr, vga_data}, {16'd4799, 16'd9});
    // Full FIFO, 17th rejected
    for (int i = 0; i < 17; i++) push_one(16'(i * 7), 8'(i % 10), 1);
    end_push();
    @(negedge clk); check("full_ready", cmd_ready, 0);
    run_frame(0, 0, 0);
    check("full_nwr", n_wr, 16);
    check("full_ready_back", cmd_ready, 1);
    // Out-of-range dropped, then cleared by next frame_req
    push_one(16'd4800, 8'd1, 1); push_one(16'd7, 8'd3, 1);
    end_push();
    run_frame(0, 0, 0);
    check("oor_nwr", n_wr, 1);
    check("oor_err", addr_err, 1);
    run_frame(0, 0, 0);
    // frame_req during PULSE ignored; pushes mid-DRAIN land in same frame
    push_one(16'd10, 8'd4, 1); push_one(16'd11, 8'd5, 1);
    end_push();
    run_frame(0, 1, 0);
    push_one(16'd20, 8'd6, 1); push_one(16'd21, 8'd7, 1); push_one(16'd22, 8'd8, 1);
    end_push();
    run_frame(0, 0, 2);
    check("mid_nwr", n_wr, 5);
    // Randomized frames
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) push_one(rand_addr(), 8'($urandom_range(0, 9)), 1);
      end_push();
      run_frame(1'($urandom % 2), 0, 0);
    end
    // Reset during a write pulse
    for (int i = 0; i < 4; i++) push_one(16'($urandom_range(0, CELLS - 1)), 8'($urandom_range(0, 9)), 1);
    end_push();
    n_act = 0; n_done = 0;
    @(posedge clk); #1 frame_req = 1;
    @(posedge clk); #1 frame_req = 0;
    t = 0;
    while (!vga_write && t < 100) begin @(negedge clk); t++; end
    check("rst_pulse_seen", vga_write, 1);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    q.delete();
    @(negedge clk);
    check("rst_mid_strobes", {vga_activate, vga_clear, vga_write, frame_done, busy}, 0);
    check("rst_mid_ready", cmd_ready, 1);
    repeat (10) @(negedge clk);
    check("rst_no_act", {8'(n_act), 8'(n_done)}, 0);
    run_frame(0, 0, 0);
    check("rst_fifo_empty", n_wr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
